// File: rtl/lp_moving_average.sv
// Multi-channel power-of-two moving-average low-pass filter with one shared accumulator datapath.
// Optional macro LPMA_ROUNDING_EN selects round-half-up instead of truncation toward -inf.
module lp_moving_average #(
  parameter int DATA_W   = 16,
  parameter int NUM_CH   = 2,
  parameter int MAX_LOG2 = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [$clog2(MAX_LOG2+1)-1:0]   win_log2,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_CH*DATA_W-1:0]        sample_in,
  output logic                            out_valid,
  output logic [NUM_CH*DATA_W-1:0]        sample_out
);

  localparam int WL_W   = $clog2(MAX_LOG2+1);
  localparam int ACC_W  = DATA_W + MAX_LOG2;
  localparam int DEPTH  = 1 << MAX_LOG2;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int FILL_W = MAX_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                   state, state_next;
  logic [CH_W-1:0]          ch;
  logic                     last_ch;
  logic                     accept;
  logic [WL_W-1:0]          w_reg, w_clamp;
  logic [NUM_CH*DATA_W-1:0] frame_q;
  logic [MAX_LOG2-1:0]      wptr, rd_ptr;
  logic [FILL_W-1:0]        fill_cnt, win_size;
  logic signed [ACC_W-1:0]  acc [NUM_CH];
  logic signed [DATA_W-1:0] hist [NUM_CH][DEPTH];
  logic signed [DATA_W-1:0] new_s, old_s;
  logic signed [ACC_W-1:0]  acc_new, rnd_bias;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b1;
    out_valid  = 1'b0;
    case (state)
      IDLE: if (in_valid) state_next = CALC;
      CALC: begin
        in_ready = 1'b0;
        if (last_ch) state_next = DONE;
      end
      DONE: begin
        out_valid  = 1'b1;
        state_next = in_valid ? CALC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept  = in_valid & in_ready;
  assign last_ch = (ch == CH_W'(NUM_CH-1));
  assign w_clamp = (win_log2 > WL_W'(MAX_LOG2)) ? WL_W'(MAX_LOG2) : win_log2;

  // The sample leaving the window only counts once enough frames have been seen since the last clear.
  always_comb begin
    win_size = FILL_W'(1) << w_reg;
    rd_ptr   = wptr - win_size[MAX_LOG2-1:0];
    new_s    = frame_q[ch*DATA_W +: DATA_W];
    old_s    = (fill_cnt >= win_size) ? hist[ch][rd_ptr] : '0;
    acc_new  = acc[ch] + ACC_W'(new_s) - ACC_W'(old_s);
`ifdef LPMA_ROUNDING_EN
    rnd_bias = (w_reg != '0) ? (ACC_W'(1) << (w_reg - 1'b1)) : '0;
`else
    rnd_bias = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst_n && state == CALC) hist[ch][wptr] <= new_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
      wptr       <= '0;
      fill_cnt   <= '0;
      w_reg      <= '0;
      ch         <= '0;
      frame_q    <= '0;
      sample_out <= '0;
    end else if (accept) begin
      frame_q <= sample_in;
      w_reg   <= w_clamp;
      ch      <= '0;
      if (w_clamp != w_reg) begin
        for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
        fill_cnt <= '0;
      end
    end else if (state == CALC) begin
      acc[ch] <= acc_new;
      if (last_ch) begin
        ch   <= '0;
        wptr <= wptr + 1'b1;
        if (fill_cnt != FILL_W'(DEPTH)) fill_cnt <= fill_cnt + 1'b1;
        // The last channel's accumulator is still in flight, so take it from acc_new.
        for (int k = 0; k < NUM_CH; k++)
          sample_out[k*DATA_W +: DATA_W] <=
            DATA_W'((((k == int'(ch)) ? acc_new : acc[k]) + rnd_bias) >>> w_reg);
      end else begin
        ch <= ch + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lp_moving_average.sv
// Directed self-checking bench for lp_moving_average (DATA_W=16, NUM_CH=2, MAX_LOG2=3).
// Expected values follow LPMA_ROUNDING_EN where the two modes differ.
module tb_lp_moving_average;

  localparam int DATA_W   = 16;
  localparam int NUM_CH   = 2;
  localparam int MAX_LOG2 = 3;
  localparam int WL_W     = $clog2(MAX_LOG2+1);

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [WL_W-1:0]          win_log2 = '0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [NUM_CH*DATA_W-1:0] sample_in = '0;
  logic                     out_valid;
  logic [NUM_CH*DATA_W-1:0] sample_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lp_moving_average #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .MAX_LOG2(MAX_LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .win_log2(win_log2), .in_valid(in_valid), .in_ready(in_ready),
    .sample_in(sample_in), .out_valid(out_valid), .sample_out(sample_out)
  );

  function automatic int chOut(input int k);
    logic signed [DATA_W-1:0] v;
    v = sample_out[k*DATA_W +: DATA_W];
    return int'(v);
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Presents one frame, waits for its acceptance and result, and checks the accept-to-output latency.
  task automatic applyStimulus(input int c0, input int c1, input int w, output int o0, output int o1);
    int n;
    o0 = 0;
    o1 = 0;
    @(negedge clk);
    sample_in = {16'(c1), 16'(c0)};
    win_log2  = WL_W'(w);
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    checkOutput("latency", n, 3);
    o0 = chOut(0);
    o1 = chOut(1);
  endtask

  task automatic runFrame(input string tag, input int c0, input int c1, input int w,
                          input int e0, input int e1);
    int o0, o1;
    applyStimulus(c0, c1, w, o0, o1);
    checkOutput({tag, "_ch0"}, o0, e0);
    checkOutput({tag, "_ch1"}, o1, e1);
  endtask

  int fill_exp[5] = '{25, 50, 75, 100, 100};
  int hs_exp[7]   = '{1, 3, 6, 10, 14, 18, 22};
`ifdef LPMA_ROUNDING_EN
  int rnd_exp[4]  = '{1, 1, 0, 0};
`else
  int rnd_exp[4]  = '{0, 0, -1, -1};
`endif
  int rnd_in[4]   = '{1, 0, -1, 0};

  initial begin
    int k, nout, seen, o0, o1;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_sample_out", int'(sample_out), 0);

    for (int i = 0; i < 5; i++)
      runFrame($sformatf("fill%0d", i), 100, -100, 2, fill_exp[i], -fill_exp[i]);

    runFrame("wchg0", 100, -100, 1, 50, -50);
    runFrame("wchg1", 100, -100, 1, 100, -100);
    runFrame("wchg2", 100, -100, 1, 100, -100);

    for (int i = 0; i < 10; i++)
      runFrame($sformatf("imp%0d", i), (i == 0) ? 800 : 0, 0, 3, (i < 8) ? 100 : 0, 0);

    for (int i = 0; i < 4; i++)
      runFrame($sformatf("rnd%0d", i), rnd_in[i], 0, 1, rnd_exp[i], 0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(32767, -32768, 3, o0, o1);
      if (i >= 7) begin
        checkOutput($sformatf("ext%0d_max", i), o0, 32767);
        checkOutput($sformatf("ext%0d_min", i), o1, -32768);
      end
    end

    // Source holds in_valid high and advances its frame only after each observed acceptance.
    k = 0;
    nout = 0;
    @(negedge clk);
    win_log2  = 2;
    sample_in = {16'd0, 16'(4)};
    in_valid  = 1'b1;
    for (int c = 0; c < 22; c++) begin
      if (c > 0) @(negedge clk);
      checkOutput($sformatf("hs_ready_c%0d", c), in_ready, int'(c % 3 == 0));
      checkOutput($sformatf("hs_valid_c%0d", c), out_valid, int'(c % 3 == 0 && c > 0));
      if (out_valid) begin
        if (nout < 7) checkOutput($sformatf("hs_out%0d", nout), chOut(0), hs_exp[nout]);
        nout++;
      end
      if (in_ready && in_valid) begin
        @(posedge clk);
        #1;
        k++;
        if (k < 7) sample_in = {16'd0, 16'(4 * (k + 1))};
        else       in_valid = 1'b0;
      end
    end
    checkOutput("hs_outputs", nout, 7);
    checkOutput("hs_accepts", k, 7);

    @(negedge clk);
    sample_in = {16'(-100), 16'(100)};
    win_log2  = 2;
    in_valid  = 1'b1;
    checkOutput("rst_pre_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkOutput("rst_no_valid", seen, 0);
    checkOutput("rst_sample_out", chOut(0), 0);
    checkOutput("rst_in_ready", in_ready, 1);
    runFrame("after_rst", 100, -100, 2, 25, -25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
